great_sub_arbiter: RTL

- Shares one streaming great_subtractor between NUM_REQ requesters.
- Each requester submits a full BITS_IN_NUM-bit A-B operation as WORDS = BITS_IN_NUM/REGISTER_SIZE word pairs, LSW first.
- Round-robin grant per whole operation; the grant is held until the subtractor's final word returns.
- Results are re-emitted with an owner tag. Sits between the modular-arithmetic front ends and the shared subtractor datapath.

---
 rtl/great_pkg.sv | 23 ++
 rtl/great_sub_arbiter_rr_pick.sv | 34 +++
 rtl/great_sub_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/great_pkg.sv
// Shared definitions for the great_subtractor arbiter slice.
//   REGISTER_SIZE_DEF / BITS_IN_NUM_DEF : default word and operand widths
//   words_per_num()                     : number of words per operand
//   arb_state_t                         : arbiter FSM state encoding
package great_pkg;

  localparam int unsigned REGISTER_SIZE_DEF = 32;
  localparam int unsigned BITS_IN_NUM_DEF   = 2048;

  // Operand width must be a multiple of the word width.
  function automatic int unsigned words_per_num(input int unsigned bits,
                                                input int unsigned reg_size);
    return bits / reg_size;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/great_sub_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_in        : request vector, one bit per requester
//   last_grant_in : most recently served requester
//   grant_c       : first requesting index after last_grant_in (wrapping)
//   any_c         : at least one request is present
module rr_pick
  import great_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned GW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [GW-1:0]      last_grant_in,
  output logic [GW-1:0]      grant_c,
  output logic               any_c
);

  int unsigned idx;

  // Search last_grant+1 .. last_grant+NUM_REQ modulo NUM_REQ; first hit wins.
  always_comb begin
    grant_c = '0;
    any_c   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant_in) + i) % NUM_REQ;
      if (!any_c && req_in[GW'(idx)]) begin
        any_c   = 1'b1;
        grant_c = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/great_sub_arbiter.sv
// Round-robin arbiter sharing one streaming great_subtractor between
// NUM_REQ requesters. Each requester streams WORDS A/B word pairs (LSW
// first); the grant is held per whole operation until the subtractor's
// final result word returns. Results are re-emitted with an owner tag.
//
// Optional feature macro: GREAT_SUB_ARB_TIMEOUT_EN adds error_out and a
// watchdog that aborts a stalled operation after TIMEOUT_CYCLES.
//
// Ports:
//   clk_in, rst_in          : clock, async active-high reset
//   req_a_in/req_b_in       : packed per-requester A/B words
//   req_valid_in            : per-requester word valid
//   req_ready_out           : per-requester word ready (granted one only)
//   sub_a_out/sub_b_out     : word pair to the subtractor
//   sub_valid_out           : word pair valid
//   sub_data_in/valid/final : subtractor result stream
//   data_out/valid_out/final_out/owner_out : tagged result stream
//   error_out               : watchdog pulse (timeout build only)
//   busy_out                : arbiter not in IDLE
module great_sub_arbiter
  import great_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE  = REGISTER_SIZE_DEF,
  parameter int unsigned BITS_IN_NUM    = BITS_IN_NUM_DEF,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned GW            = $clog2(NUM_REQ)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0] req_a_in,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0] req_b_in,
  input  logic [NUM_REQ-1:0]               req_valid_in,
  output logic [NUM_REQ-1:0]               req_ready_out,
  output logic [REGISTER_SIZE-1:0]         sub_a_out,
  output logic [REGISTER_SIZE-1:0]         sub_b_out,
  output logic                             sub_valid_out,
  input  logic [REGISTER_SIZE-1:0]         sub_data_in,
  input  logic                             sub_valid_in,
  input  logic                             sub_final_in,
  output logic [REGISTER_SIZE-1:0]         data_out,
  output logic                             valid_out,
  output logic                             final_out,
  output logic [GW-1:0]                    owner_out,
`ifdef GREAT_SUB_ARB_TIMEOUT_EN
  output logic                             error_out,
`endif
  output logic                             busy_out
);

  localparam int unsigned WORDS = words_per_num(BITS_IN_NUM, REGISTER_SIZE);
  localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  arb_state_t               state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_REQ-1:0]       ready_q, ready_d;
  logic [REGISTER_SIZE-1:0] sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic                     sub_valid_q, sub_valid_d;
  logic [REGISTER_SIZE-1:0] data_q, data_d;
  logic                     valid_q, valid_d, final_q, final_d;
  logic [GW-1:0]            owner_q, owner_d;
  logic                     busy_q, busy_d;

  logic [GW-1:0]            pick_grant_c;
  logic                     pick_any_c;
  logic                     accept_c;
  logic [REGISTER_SIZE-1:0] word_a_c, word_b_c;

`ifdef GREAT_SUB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_in        (req_valid_in),
    .last_grant_in (last_grant_q),
    .grant_c       (pick_grant_c),
    .any_c         (pick_any_c)
  );

  // ready_q is only ever the grant one-hot during STREAM, so this is the handshake.
  assign accept_c = (state_q == STREAM) && |(ready_q & req_valid_in);
  assign word_a_c = req_a_in[grant_q*REGISTER_SIZE +: REGISTER_SIZE];
  assign word_b_c = req_b_in[grant_q*REGISTER_SIZE +: REGISTER_SIZE];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    sub_valid_d  = accept_c;
    sub_a_d      = accept_c ? word_a_c : sub_a_q;
    sub_b_d      = accept_c ? word_b_c : sub_b_q;
    data_d       = sub_data_in;
    valid_d      = sub_valid_in;
    final_d      = sub_final_in;
    owner_d      = grant_q;
`ifdef GREAT_SUB_ARB_TIMEOUT_EN
    tmo_d        = '0;
    error_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        ready_d = '0;
        if (pick_any_c) begin
          grant_d = pick_grant_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Ready is registered, so raise it here to be visible in STREAM.
        ready_d = NUM_REQ'(1) << grant_q;
        state_d = STREAM;
      end
      STREAM: begin
        if (accept_c) begin
          if (cnt_q == CW'(WORDS - 1)) begin
            cnt_d   = '0;
            ready_d = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        ready_d = '0;
        if (sub_valid_in && sub_final_in) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef GREAT_SUB_ARB_TIMEOUT_EN
    // Watchdog: any forward or return traffic counts as progress.
    if (state_q == STREAM || state_q == DRAIN) begin
      if (accept_c || sub_valid_in) begin
        tmo_d = '0;
      end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
        tmo_d = tmo_q + TW'(1);
      end else begin
        tmo_d = tmo_q;
      end
      if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
        error_d      = 1'b1;
        state_d      = IDLE;
        last_grant_d = grant_q;
        ready_d      = '0;
        cnt_d        = '0;
        tmo_d        = '0;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      cnt_q        <= '0;
      ready_q      <= '0;
      sub_a_q      <= '0;
      sub_b_q      <= '0;
      sub_valid_q  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      final_q      <= 1'b0;
      owner_q      <= '0;
      busy_q       <= 1'b0;
`ifdef GREAT_SUB_ARB_TIMEOUT_EN
      tmo_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      sub_a_q      <= sub_a_d;
      sub_b_q      <= sub_b_d;
      sub_valid_q  <= sub_valid_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      final_q      <= final_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
`ifdef GREAT_SUB_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
      error_q      <= error_d;
`endif
    end
  end

  assign req_ready_out = ready_q;
  assign sub_a_out     = sub_a_q;
  assign sub_b_out     = sub_b_q;
  assign sub_valid_out = sub_valid_q;
  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign final_out     = final_q;
  assign owner_out     = owner_q;
  assign busy_out      = busy_q;
`ifdef GREAT_SUB_ARB_TIMEOUT_EN
  assign error_out     = error_q;
`endif

endmodule
